// File: rtl/key_debounce8.sv
// Eight-channel key synchronizer/debouncer feeding a CD4532 priority encoder.
// Optional macro KEY_ACTIVE_LOW_EN: inverts key_in (pull-up buttons, 0 = pressed).
module key_debounce8 #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_in,
    output logic [7:0] key_out,
    output logic [7:0] key_press,
    output logic       any_press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [7:0]       key_lvl;
    logic [7:0]       s1;
    logic [7:0]       s2;
    logic [7:0]       flip;
    logic [7:0]       press_next;
    logic [CNT_W-1:0] cnt      [8];
    logic [CNT_W-1:0] cnt_next [8];

`ifdef KEY_ACTIVE_LOW_EN
    assign key_lvl = ~key_in;
`else
    assign key_lvl = key_in;
`endif

    // Any cycle where the synchronized level agrees with key_out restarts the count.
    always_comb begin
        flip = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_next[i] = '0;
            if (s2[i] != key_out[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    flip[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Only a 0->1 flip of the debounced level produces a press pulse.
    assign press_next = flip & ~key_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            key_out   <= '0;
            key_press <= '0;
            any_press <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1        <= key_lvl;
            s2        <= s1;
            key_out   <= key_out ^ flip;
            key_press <= press_next;
            any_press <= |press_next;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: doc/key_debounce8.md
# key_debounce8

Eight-channel key synchronizer and debouncer that sits directly upstream of the CD4532 8-to-3 priority encoder. It takes eight raw, asynchronous push-button lines and produces eight clean, single-clock-domain levels for the encoder's `I[7:0]` input. It also produces one-cycle press pulses, so downstream logic can latch the encoder's `Y`/`GS` result exactly once per key press.

## Interface
Parameters:
- `DB_CYCLES`, default 500000 — consecutive stable cycles required before an output level changes (10 ms at 50 MHz); legal range 2 .. 2^CNT_W.
- `CNT_W`, default 19 — width of each per-channel counter; must satisfy 2^CNT_W ≥ DB_CYCLES.

Ports:
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `key_in` input 8 — raw key lines, asynchronous to `clk`; bit i = key i.
- `key_out` output 8 — debounced level, 1 = pressed; drives encoder `I[7:0]`.
- `key_press` output 8 — one-cycle pulse on a debounced 0→1 transition of the matching bit.
- `any_press` output 1 — OR of `key_press`, registered in the same cycle as `key_press`.

## Operation
- **Synchronizer.** Each bit passes through a 2-flop synchronizer (`s1`, `s2`). The pressed polarity is applied before `s1` (see Configuration).
- **Per-channel counter `cnt[i]`** (CNT_W bits), updated every cycle:
  - If `s2[i] == key_out[i]`: `cnt[i]` ← 0.
  - Else, if `cnt[i] == DB_CYCLES-1`: `key_out[i]` toggles and `cnt[i]` ← 0.
  - Else: `cnt[i]` ← `cnt[i]` + 1.
- **Glitch rejection.** Any cycle in which `s2[i]` matches `key_out[i]` restarts the count. A pulse or bounce shorter than `DB_CYCLES` synchronized cycles never reaches `key_out`.
- **Channel independence.** Channels are fully independent. Several bits may flip on the same edge, and the resulting `key_press` pulses appear together. Priority resolution is left to the encoder.
- **Counter range.** The counter never exceeds `DB_CYCLES-1`, so it cannot wrap.
- **Press pulse.** `key_press[i]` is 1 only in the cycle right after `key_out[i]` went 0→1, i.e. it is registered on the same edge as the flip. A 1→0 flip produces no pulse. A held key produces exactly one pulse.
- **Reset.** While `rst_n` is low, all state is forced to its reset value:
  - `s1`, `s2`, `key_out`, `cnt`, `key_press`, `any_press` = 0.
  - "0" means inactive after polarity correction.
- **Reset mid-operation.** Asserting reset during a partial count discards it. After release, a key already held is re-qualified from scratch and produces one `key_press`.

## Timing
- **Latency.** A raw change that stays stable is visible on `key_out` at the (DB_CYCLES+2)-th rising edge after the change, where edge 1 is the first edge that samples the new value into `s1`.
  - 2 edges of synchronizer.
  - DB_CYCLES mismatch edges.
- **Pulse alignment.** `key_press` and `any_press` assert on the same edge as the `key_out` rise and last exactly one cycle.
- **Release.** Release latency is identical: DB_CYCLES+2 edges to 0.
- **Reset release.** The first counting edge is the first rising edge after `rst_n` goes high. No output toggles earlier than DB_CYCLES+2 edges after reset release.
- **Registered outputs.** All outputs are registered; there is no combinational path from `key_in` to any output.

## Configuration
- **Macro `KEY_ACTIVE_LOW_EN`.**
  - **Defined:** `key_in` is inverted before `s1`. Pull-up buttons read 0 when pressed, and `key_in` = 8'hFF means no key pressed.
  - **Not defined:** `key_in` is taken as-is, so 1 = pressed.
- **Unaffected by the macro:** `key_out`, `key_press`, `any_press` and all reset values are active-high and unchanged either way.

## Test plan
All scenarios use `DB_CYCLES=4`, `CNT_W=3`, macro undefined.
- **Reset.** Hold `rst_n`=0 with `key_in`=8'hFF → all outputs are 0. Release reset → `key_out`=8'hFF at edge 6, `key_press`=8'hFF and `any_press`=1 for exactly that one cycle.
- **Single clean press.** `key_in` 0→8'h08 and held → `key_out`=8'h08 at edge 6, `key_press`=8'h08 for one cycle then 0. Release → `key_out`=0 at edge 6 after release, with no pulse.
- **Bounce.** On bit 0, apply pattern 1,1,1,0,1,1,1,0 (one value per cycle), then hold 1 → `key_out[0]` stays 0 through the bouncing, then rises 6 edges after the last 0→1 transition, with exactly one `key_press[0]` pulse.
- **Simultaneous keys.** `key_in`=8'h81 applied in one cycle → `key_out`=8'h81 and `key_press`=8'h81 on the same edge; encoder shows `Y`=3'b111, `GS`=1.
- **Reset mid-count.** Apply `key_in`=8'h10, pulse `rst_n` low at edge 4 for 1 cycle → `key_out` stays 0 until 6 edges after reset release, then rises with one `key_press[4]`.
- **Active-low build.** Compile with `KEY_ACTIVE_LOW_EN` defined. `key_in`=8'hFF → `key_out` stays 0. `key_in`=8'hFB → `key_out`=8'h04 at edge 6.
